// File: rtl/posit_add_pkg.sv
// Shared types and sizing helpers for the posit adder datapath.
//
// Contents:
//   calc_s(n)        - shifter stage count for an n-bit fraction ($clog2(n))
//   calc_sw(n, es)   - signed scale width: calc_s(n) + es + 1
//   POSIT_N/ES/S/SW  - default configuration (N=8, es=4)
//   posit_dec_t      - decoded operand bundle {sign, scale, frac, zero, nar}
//   posit_aligned_t  - aligned operand pair handed to the mantissa adder
//
// The packed structs are sized for the default configuration.
package posit_add_pkg;

    function automatic int calc_s(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int calc_sw(input int n, input int es);
        return calc_s(n) + es + 1;
    endfunction

    localparam int POSIT_N  = 8;
    localparam int POSIT_ES = 4;
    localparam int POSIT_S  = calc_s(POSIT_N);
    localparam int POSIT_SW = calc_sw(POSIT_N, POSIT_ES);

    typedef struct packed {
        logic                       sign;
        logic signed [POSIT_SW-1:0] scale;
        logic [POSIT_N-1:0]         frac;
        logic                       zero;
        logic                       nar;
    } posit_dec_t;

    typedef struct packed {
        logic                       lg_sign;
        logic signed [POSIT_SW-1:0] lg_scale;
        logic [POSIT_N-1:0]         lg_frac;
        logic [POSIT_N-1:0]         sm_frac;
        logic                       sticky;
        logic                       eff_sub;
        logic                       zero;
        logic                       nar;
    } posit_aligned_t;

endpackage

// File: rtl/align_rshift_sticky.sv
// Log-stage barrel right shifter with saturating shift amount and sticky bit.
//
// Ports:
//   data_i   [N-1:0] value to shift
//   amt_i    [S:0]   shift amount, 0..N; N means "everything shifted out"
//   data_o   [N-1:0] data_i >> amt_i (0 when amt_i >= N)
//   sticky_o         OR of every bit shifted out
//
// Build option: POSIT_ALIGN_STICKY_EN. When undefined the sticky OR-tree is
// not built and sticky_o is tied low (pure truncation).
module align_rshift_sticky #(
    parameter int N = 8,
    parameter int S = 3
) (
    input  logic [N-1:0] data_i,
    input  logic [S:0]   amt_i,
    output logic [N-1:0] data_o,
    output logic         sticky_o
);

    logic sat;
    assign sat = (amt_i >= (S+1)'(N));

    // Stage gi shifts by 2^gi when amt_i[gi] is set.
    for (genvar gi = 0; gi < S; gi++) begin : g_stage
        localparam int SH = 1 << gi;
        logic [N-1:0] din;
        logic [N-1:0] dout;
        if (gi == 0) begin : g_first
            assign din = data_i;
        end else begin : g_next
            assign din = g_stage[gi-1].dout;
        end
        assign dout = amt_i[gi] ? (din >> SH) : din;
`ifdef POSIT_ALIGN_STICKY_EN
        logic stk_in;
        logic stk_out;
        if (gi == 0) begin : g_stk_first
            assign stk_in = 1'b0;
        end else begin : g_stk_next
            assign stk_in = g_stage[gi-1].stk_out;
        end
        // Bits leaving this stage are the low SH bits of its input.
        assign stk_out = stk_in | (amt_i[gi] & (|din[SH-1:0]));
`endif
    end

    assign data_o = sat ? '0 : g_stage[S-1].dout;

`ifdef POSIT_ALIGN_STICKY_EN
    assign sticky_o = sat ? (|data_i) : g_stage[S-1].stk_out;
`else
    assign sticky_o = 1'b0;
`endif

endmodule

// File: rtl/posit_align_stage.sv
// Two-stage operand alignment for the posit adder.
//   Stage 1: order operands by magnitude, handle zero/NaR, compute the
//            saturated scale difference.
//   Stage 2: right-shift the smaller fraction and derive the sticky bit.
// Valid/ready on both sides, one pair per cycle, 2-cycle latency.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready                input handshake (in_ready is
//                                    combinational from out_ready)
//   a_*/b_* sign, scale, frac,       decoded operands
//           zero, nar
//   out_valid/out_ready              output handshake
//   lg_sign, lg_scale, lg_frac       larger-magnitude operand
//   sm_frac, sticky                  aligned smaller fraction and sticky bit
//   eff_sub, out_zero, out_nar       effective subtraction, special flags
//
// Build option: POSIT_ALIGN_STICKY_EN enables sticky generation; otherwise
// sticky is always 0.
module posit_align_stage
    import posit_add_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int es = POSIT_ES,
    localparam int S  = calc_s(N),
    localparam int SW = S + es + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          a_sign,
    input  logic          b_sign,
    input  logic [SW-1:0] a_scale,
    input  logic [SW-1:0] b_scale,
    input  logic [N-1:0]  a_frac,
    input  logic [N-1:0]  b_frac,
    input  logic          a_zero,
    input  logic          b_zero,
    input  logic          a_nar,
    input  logic          b_nar,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          lg_sign,
    output logic [SW-1:0] lg_scale,
    output logic [N-1:0]  lg_frac,
    output logic [N-1:0]  sm_frac,
    output logic          sticky,
    output logic          eff_sub,
    output logic          out_zero,
    output logic          out_nar
);

    posit_dec_t     a_dec, b_dec, lg_dec, sm_dec;
    posit_aligned_t s1_d, s1_q, s2_d, s2_q;
    logic [S:0]     s1_amt_d, s1_amt_q, amt_sat;
    logic [SW:0]    diff_full;
    logic           a_wins;
    logic           s1_valid_q, s2_valid_q;
    logic           s1_load, s2_load;
    logic [N-1:0]   sh_frac;
    logic           sh_sticky;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    assign a_dec = '{sign: a_sign, scale: a_scale, frac: a_frac, zero: a_zero, nar: a_nar};
    assign b_dec = '{sign: b_sign, scale: b_scale, frac: b_frac, zero: b_zero, nar: b_nar};

    // Ties on scale and frac go to a.
    assign a_wins = ($signed(a_dec.scale) > $signed(b_dec.scale)) ||
                    ((a_dec.scale == b_dec.scale) && (a_dec.frac >= b_dec.frac));
    assign lg_dec = a_wins ? a_dec : b_dec;
    assign sm_dec = a_wins ? b_dec : a_dec;

    // One extra bit so the difference of two extreme scales cannot wrap;
    // after the swap it is non-negative and can be read as unsigned.
    assign diff_full = {lg_dec.scale[SW-1], lg_dec.scale} - {sm_dec.scale[SW-1], sm_dec.scale};
    assign amt_sat   = (diff_full >= (SW+1)'(N)) ? (S+1)'(N) : diff_full[S:0];

    always_comb begin
        s1_d     = '0;
        s1_amt_d = '0;
        if (a_nar || b_nar) begin
            s1_d.nar = 1'b1;
        end else if (a_zero && b_zero) begin
            s1_d.zero = 1'b1;
        end else if (a_zero || b_zero) begin
            // The non-zero operand passes straight through; nothing to align.
            s1_d.lg_sign  = a_zero ? b_sign  : a_sign;
            s1_d.lg_scale = a_zero ? b_scale : a_scale;
            s1_d.lg_frac  = a_zero ? b_frac  : a_frac;
        end else begin
            s1_d.lg_sign  = lg_dec.sign;
            s1_d.lg_scale = lg_dec.scale;
            s1_d.lg_frac  = lg_dec.frac;
            s1_d.sm_frac  = sm_dec.frac;
            s1_d.eff_sub  = lg_dec.sign ^ sm_dec.sign;
            s1_amt_d      = amt_sat;
        end
    end

    align_rshift_sticky #(
        .N(N),
        .S(S)
    ) u_shift (
        .data_i   (s1_q.sm_frac),
        .amt_i    (s1_amt_q),
        .data_o   (sh_frac),
        .sticky_o (sh_sticky)
    );

    always_comb begin
        s2_d         = s1_q;
        s2_d.sm_frac = sh_frac;
        s2_d.sticky  = sh_sticky;
    end

    // Data registers only capture real transfers so idle bubbles do not
    // toggle the downstream datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s1_amt_q   <= '0;
            s2_q       <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_q     <= s1_d;
                    s1_amt_q <= s1_amt_d;
                end
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_q <= s2_d;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign lg_sign   = s2_q.lg_sign;
    assign lg_scale  = s2_q.lg_scale;
    assign lg_frac   = s2_q.lg_frac;
    assign sm_frac   = s2_q.sm_frac;
    assign sticky    = s2_q.sticky;
    assign eff_sub   = s2_q.eff_sub;
    assign out_zero  = s2_q.zero;
    assign out_nar   = s2_q.nar;

endmodule

// File: tb/tb_posit_align_stage.sv
// Self-checking bench for posit_align_stage (N=8, es=4).
// Observed word layout: {lg_sign, lg_scale, lg_frac, sm_frac, sticky,
// eff_sub, out_zero, out_nar} = 29 bits.
module tb_posit_align_stage;

`ifdef POSIT_ALIGN_STICKY_EN
    localparam bit STK_EN = 1'b1;
`else
    localparam bit STK_EN = 1'b0;
`endif

    logic       clk, rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic       a_sign, b_sign, a_zero, b_zero, a_nar, b_nar;
    logic [7:0] a_scale, b_scale, a_frac, b_frac;
    logic       lg_sign, sticky, eff_sub, out_zero, out_nar;
    logic [7:0] lg_scale, lg_frac, sm_frac;
    logic [28:0] obs;

    int checks = 0;
    int errors = 0;

    posit_align_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_sign(a_sign), .b_sign(b_sign),
        .a_scale(a_scale), .b_scale(b_scale),
        .a_frac(a_frac), .b_frac(b_frac),
        .a_zero(a_zero), .b_zero(b_zero),
        .a_nar(a_nar), .b_nar(b_nar),
        .out_valid(out_valid), .out_ready(out_ready),
        .lg_sign(lg_sign), .lg_scale(lg_scale), .lg_frac(lg_frac),
        .sm_frac(sm_frac), .sticky(sticky), .eff_sub(eff_sub),
        .out_zero(out_zero), .out_nar(out_nar)
    );

    assign obs = {lg_sign, lg_scale, lg_frac, sm_frac, sticky, eff_sub, out_zero, out_nar};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: pick the larger magnitude, align the other by plain
    // integer arithmetic.
    function automatic logic [28:0] ref_align(
        input bit as, input int asc, input logic [7:0] af, input bit az, input bit an,
        input bit bs, input int bsc, input logic [7:0] bf, input bit bz, input bit bn);
        bit ls, ss, stk;
        int lsc, ssc, d;
        logic [7:0] lf, sf, sh;
        if (an || bn) return 29'd1;
        if (az && bz) return 29'd2;
        if (az) return {bs, 8'(bsc), bf, 8'h00, 4'b0000};
        if (bz) return {as, 8'(asc), af, 8'h00, 4'b0000};
        if ((asc > bsc) || (asc == bsc && af >= bf)) begin
            ls = as; lsc = asc; lf = af; ss = bs; ssc = bsc; sf = bf;
        end else begin
            ls = bs; lsc = bsc; lf = bf; ss = as; ssc = asc; sf = af;
        end
        d = lsc - ssc;
        if (d >= 8) begin
            sh  = 8'h00;
            stk = (sf != 0);
        end else begin
            sh  = sf >> d;
            stk = ((int'(sf) % (1 << d)) != 0);
        end
        if (!STK_EN) stk = 1'b0;
        return {ls, 8'(lsc), lf, sh, stk, ls ^ ss, 2'b00};
    endfunction

    task automatic set_pair(input bit as, input int asc, input logic [7:0] af, input bit az, input bit an,
                            input bit bs, input int bsc, input logic [7:0] bf, input bit bz, input bit bn);
        a_sign = as; a_scale = 8'(asc); a_frac = af; a_zero = az; a_nar = an;
        b_sign = bs; b_scale = 8'(bsc); b_frac = bf; b_zero = bz; b_nar = bn;
    endtask

    task automatic rand_operand(output bit s, output int sc, output logic [7:0] f,
                                output bit z, output bit n);
        int cls;
        cls = int'($urandom_range(0, 9));
        s   = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 0) sc = int'($urandom_range(0, 20)) - 10;
        else sc = int'($signed(8'($urandom_range(0, 255))));
        f = {1'b1, 7'($urandom_range(0, 127))};
        z = (cls == 1);
        n = (cls == 0);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if (obs !== 29'd0) begin errors++; $display("FAIL reset_data got %h want 0", obs); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset: out_valid=%b in_ready=%b data=%h", out_valid, in_ready, obs);
    endtask

    typedef struct {
        bit as; int asc; logic [7:0] af; bit az; bit an;
        bit bs; int bsc; logic [7:0] bf; bit bz; bit bn;
        bit ls; int lsc; logic [7:0] lf; logic [7:0] sm; bit stk; bit eff; bit z; bit n;
    } vec_t;

    task automatic test_directed;
        vec_t v[10];
        logic [28:0] exp_w;
        v[0] = '{0,   5, 8'hC0, 0, 0, 1,   2, 8'hA1, 0, 0, 0,   5, 8'hC0, 8'h14, 1, 1, 0, 0};
        v[1] = '{0,  -3, 8'h90, 0, 0, 1,  -3, 8'hA0, 0, 0, 1,  -3, 8'hA0, 8'h90, 0, 1, 0, 0};
        v[2] = '{0,  10, 8'h80, 0, 0, 0,  -2, 8'h81, 0, 0, 0,  10, 8'h80, 8'h00, 1, 0, 0, 0};
        v[3] = '{0,   7, 8'hF0, 0, 0, 1,  -9, 8'hC5, 0, 1, 0,   0, 8'h00, 8'h00, 0, 0, 0, 1};
        v[4] = '{0,   3, 8'hC0, 1, 0, 1,  -4, 8'hB0, 1, 0, 0,   0, 8'h00, 8'h00, 0, 0, 1, 0};
        v[5] = '{0,  60, 8'hE0, 1, 0, 1,  -5, 8'hC3, 0, 0, 1,  -5, 8'hC3, 8'h00, 0, 0, 0, 0};
        v[6] = '{0,   4, 8'hB0, 0, 0, 1,   4, 8'hB0, 0, 0, 0,   4, 8'hB0, 8'hB0, 0, 1, 0, 0};
        v[7] = '{1,   0, 8'hFF, 0, 0, 1,  -7, 8'hFF, 0, 0, 1,   0, 8'hFF, 8'h01, 1, 0, 0, 0};
        v[8] = '{0,   8, 8'h80, 0, 0, 0,   0, 8'h80, 0, 0, 0,   8, 8'h80, 8'h00, 1, 0, 0, 0};
        v[9] = '{0,-100, 8'h80, 0, 0, 1, 100, 8'h80, 0, 0, 1, 100, 8'h80, 8'h00, 1, 1, 0, 0};
        for (int i = 0; i < 10; i++) begin
            exp_w = {v[i].ls, 8'(v[i].lsc), v[i].lf, v[i].sm, v[i].stk & STK_EN, v[i].eff, v[i].z, v[i].n};
            set_pair(v[i].as, v[i].asc, v[i].af, v[i].az, v[i].an,
                     v[i].bs, v[i].bsc, v[i].bf, v[i].bz, v[i].bn);
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_accept in_ready=%b want 1", i, in_ready); end
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early out_valid=%b want 0", i, out_valid); end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || obs !== exp_w) begin
                errors++;
                $display("FAIL dir%0d_result valid=%b got %h want %h", i, out_valid, obs, exp_w);
            end
            $display("directed %0d: got %h want %h", i, obs, exp_w);
            @(posedge clk); #1;
        end
    endtask

    // rnd=0: 6 back-to-back pairs with out_ready low on cycles 3..5.
    // rnd=1: random in_valid/out_ready and random operands.
    task automatic test_stream(input int n, input bit rnd);
        logic [28:0] q[$];
        int  sent, cyc;
        bit  have, saw_block, exp_rdy;
        bit  as, bs, az, bz, an, bn;
        int  asc, bsc;
        logic [7:0] af, bf;
        sent = 0; cyc = 0; have = 0; saw_block = 0;
        while ((sent < n || q.size() > 0) && cyc < n * 20 + 50) begin
            if (!have && sent < n) begin
                rand_operand(as, asc, af, az, an);
                rand_operand(bs, bsc, bf, bz, bn);
                if ($urandom_range(0, 2) == 0) bsc = asc;
                if ($urandom_range(0, 3) == 0) bf = af;
                set_pair(as, asc, af, az, an, bs, bsc, bf, bz, bn);
                have = 1;
            end
            in_valid  = have && (!rnd || $urandom_range(0, 3) != 0);
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= 3 && cyc <= 5);
            @(negedge clk);
            // Two slots of storage; a full pipe only accepts when it drains.
            exp_rdy = (q.size() < 2) || out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL stream_in_ready cyc=%0d got %b want %b", cyc, in_ready, exp_rdy);
            end
            if (!in_ready) saw_block = 1;
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_spurious cyc=%0d got %h want no output", cyc, obs);
                end else begin
                    if (obs !== q[0]) begin
                        errors++;
                        $display("FAIL stream_data cyc=%0d got %h want %h", cyc, obs, q[0]);
                    end
                    if (out_ready) begin
                        $display("stream cyc=%0d out %h", cyc, obs);
                        void'(q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_align(as, asc, af, az, an, bs, bsc, bf, bz, bn));
                sent++;
                have = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (q.size() != 0 || sent != n) begin
            errors++;
            $display("FAIL stream_drain sent=%0d left=%0d want sent=%0d left=0", sent, q.size(), n);
        end
        if (!rnd) begin
            checks++;
            if (!saw_block) begin errors++; $display("FAIL stream_backpressure in_ready never 0, want a drop"); end
        end
    endtask

    task automatic test_back_to_back;
        test_stream(6, 1'b0);
    endtask

    task automatic test_random;
        test_stream(300, 1'b1);
    endtask

    task automatic test_reset_mid;
        logic [28:0] exp_w;
        out_ready = 1'b0;
        set_pair(0, 20, 8'hC1, 0, 0, 1, 3, 8'h9F, 0, 0);
        in_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_full out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== 29'd0) begin
            errors++;
            $display("FAIL rstmid_clear out_valid=%b in_ready=%b data=%h want 0 1 0", out_valid, in_ready, obs);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ghost out_valid=%b want 0", out_valid); end
        set_pair(1, -6, 8'hB7, 0, 0, 0, -9, 8'hE5, 0, 0);
        exp_w = ref_align(1, -6, 8'hB7, 0, 0, 0, -9, 8'hE5, 0, 0);
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_accept in_ready=%b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early out_valid=%b want 0", out_valid); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || obs !== exp_w) begin
            errors++;
            $display("FAIL rstmid_result valid=%b got %h want %h", out_valid, obs, exp_w);
        end
        $display("reset_mid: post-reset pair got %h want %h", obs, exp_w);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_pair(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
        #2 rst_n = 1'b0;
        test_reset;
        test_directed;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
